// File: rtl/ext_unit_pipe.sv
// Immediate / load-lane extender with a registered valid/ready output stage.
// A 2-entry main+skid buffer decouples in_ready from out_ready.
`default_nettype none

module ext_unit_pipe #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_mode,
  input  logic [1:0]      in_offset,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err
);

  localparam logic [2:0] MODE_ZEXT = 3'b000;
  localparam logic [2:0] MODE_SEXT = 3'b001;
  localparam logic [2:0] MODE_LUI  = 3'b010;
  localparam logic [2:0] MODE_BOFF = 3'b011;
  localparam logic [2:0] MODE_LB   = 3'b100;
  localparam logic [2:0] MODE_LBU  = 3'b101;
  localparam logic [2:0] MODE_LH   = 3'b110;
  localparam logic [2:0] MODE_LHU  = 3'b111;

  logic [IMM_W-1:0] imm;
  logic [XLEN-1:0]  imm_zext;
  logic [XLEN-1:0]  imm_sext;
  logic [XLEN-1:0]  imm_lui;
  logic [XLEN-1:0]  imm_boff;
  logic [31:0]      word;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [XLEN-1:0]  res_data;
  logic             res_err;

  assign imm      = in_data[IMM_W-1:0];
  assign imm_zext = {{(XLEN-IMM_W){1'b0}}, imm};
  assign imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_lui  = {imm, {(XLEN-IMM_W){1'b0}}};
  assign imm_boff = {imm_sext[XLEN-3:0], 2'b00};

  // Loads only ever see the low 32 bits, whatever XLEN is.
  assign word   = in_data[31:0];
  assign lane_h = in_offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    lane_b = word[7:0];
    case (in_offset)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
  end

  always_comb begin
    res_data = imm_zext;
    res_err  = 1'b0;
    case (in_mode)
      MODE_ZEXT: res_data = imm_zext;
      MODE_SEXT: res_data = imm_sext;
      MODE_LUI:  res_data = imm_lui;
      MODE_BOFF: res_data = imm_boff;
      MODE_LB:   res_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      MODE_LBU:  res_data = {{(XLEN-8){1'b0}}, lane_b};
      MODE_LH, MODE_LHU: begin
        if (in_offset[0]) begin
          res_data = '0;
          res_err  = 1'b1;
        end else if (in_mode == MODE_LH) begin
          res_data = {{(XLEN-16){lane_h[15]}}, lane_h};
        end else begin
          res_data = {{(XLEN-16){1'b0}}, lane_h};
        end
      end
      default: res_data = imm_zext;
    endcase
  end

  logic [1:0]      occ;
  logic [XLEN-1:0] m_data;
  logic            m_err;
  logic [XLEN-1:0] s_data;
  logic            s_err;
  logic            accept;
  logic            pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = m_data;
  assign out_err   = m_err;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      m_data <= '0;
      m_err  <= 1'b0;
      s_data <= '0;
      s_err  <= 1'b0;
    end else begin
      if (accept && !pop) begin
        if (occ == 2'd0) begin
          m_data <= res_data;
          m_err  <= res_err;
        end else begin
          s_data <= res_data;
          s_err  <= res_err;
        end
        occ <= occ + 2'd1;
      end else if (!accept && pop) begin
        if (occ == 2'd2) begin
          m_data <= s_data;
          m_err  <= s_err;
        end
        occ <= occ - 2'd1;
      end else if (accept && pop) begin
        // Only reachable at occ=1: the popped head is replaced in place.
        m_data <= res_data;
        m_err  <= res_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Parametrised, pipelined successor to the datapath's combinational immediate extender.
- Widens the immediate and performs load-data lane extraction and extension: LB/LBU/LH/LHU lane extraction, zero/sign immediate extension, LUI and branch-offset forms, all selected by a mode field.
- Sits between decode/memory-read and writeback/ALU operand mux in the pipelined MIPS core.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates a transfer.

Parameters:
- XLEN, 32, output and load-word width; must be a multiple of 16 and at least 32.
- IMM_W, 16, immediate field width taken from in_data[IMM_W-1:0]; must satisfy 2 <= IMM_W <= XLEN-2 so the branch form fits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_mode  input  3  operation select; encodings under Behaviour.
- in_offset  input  2  byte address low bits for the load modes; ignored otherwise.
- in_data  input  XLEN  immediate (low IMM_W bits) or raw load word.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  XLEN  extended result.
- out_err  output  1  misaligned halfword load flag, qualified by out_valid.

Behaviour:
- Modes, with s = in_data[IMM_W-1:0]:
  - 000 ZEXT: s zero-extended to XLEN.
  - 001 SEXT: s sign-extended to XLEN.
  - 010 LUI: s placed in bits [XLEN-1:XLEN-IMM_W]; low bits zero.
  - 011 BOFF: sign-extend s, then shift left by 2 (XLEN bits kept).
  - 100 LB: byte at lane in_offset (bits 8*off+7..8*off), sign-extended.
  - 101 LBU: same byte lane, zero-extended.
  - 110 LH: halfword lane in_offset[1] (bits 16*h+15..16*h), sign-extended.
  - 111 LHU: same halfword lane, zero-extended.
- Endianness: little-endian lane numbering; lane 0 = in_data[7:0].
- Load modes for XLEN > 32 use only in_data[31:0].
- LH/LHU with in_offset[0]=1: out_data = 0, out_err = 1.
- out_err = 0 for every other request.
- Computation is combinational on the input side. The result and out_err are captured together as one entry.
- Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Latency: 1 cycle. A request accepted at edge N appears on out_* after edge N (out_valid=1 in cycle N+1) when the buffer is otherwise empty.
- Storage: main output register (M) plus skid register (S). Occupancy count occ is 0..2.
- in_ready = (occ < 2). It is registered-derived; no combinational path from out_ready to in_ready.
- out_valid = (occ > 0). out_data/out_err always reflect M.
- Occupancy transitions:
  - Accept without pop: if occ=0, write M; if occ=1, write S. occ+1.
  - Pop without accept: M <= S when occ=2. occ-1.
  - Simultaneous accept and pop:
    - occ=1: M <= new. occ unchanged.
    - occ=2: not possible, because in_ready=0.
- Ordering is strictly FIFO.
- When out_valid=1 and out_ready=0, out_data/out_err are held stable.
- in_* inputs are ignored when in_valid=0 or in_ready=0.
- Reset (async, any time, including mid-transfer):
  - occ=0, M=S=0, out_valid=0, out_data=0, out_err=0.
  - in_ready=1 from the first edge after rst_n deasserts.
  - In-flight entries are discarded.
- X-safety: M/S update only on accept or shift; no update from idle inputs.

Test Plan:
1. XLEN=32. Mode 001, in_data=0x0000_8001, out_ready=1 -> out_data=0xFFFF_8001 one cycle later. Mode 000 with the same data -> 0x0000_8001.
2. LUI 0x1234 -> 0x1234_0000. BOFF 0xFFFF -> 0xFFFF_FFFC. BOFF 0x0004 -> 0x0000_0010.
3. Load word 0x80FF_7F01, out_ready held at 1:
   - LB offsets 0..3 -> 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80.
   - LBU offset 3 -> 0x0000_0080.
   - LH offset 2 -> 0xFFFF_80FF.
   - LHU offset 2 -> 0x0000_80FF.
   - LH offset 1 -> out_data=0, out_err=1.
4. Back-pressure: out_ready=0, send SEXT 0x0001 then SEXT 0x0002 back-to-back -> in_ready=0 after the second accept; out_data held at 0x0000_0001. Raise out_ready -> 0x0000_0001 then 0x0000_0002 on consecutive cycles; no loss or duplication.
5. Streaming: in_valid=1 and out_ready=1 continuously for 8 requests with data 1..8 -> 8 results in order, one per cycle. in_ready stays 1 throughout.
6. Reset: with occ=2, assert rst_n=0 mid-cycle -> out_valid, out_data and out_err are 0 immediately (asynchronously). After release, in_ready=1, and no stale entry ever appears on out_*.
